// File: rtl/mult_secuencial_param.sv
// mult_secuencial_param
//   Sequential WIDTH x WIDTH multiplier, one multiplier bit per clock.
//   Unsigned mode uses shift-add; signed mode uses radix-2 Booth recoding.
//   Both modes share one datapath: the multiplicand is extended to 2*WIDTH
//   bits and shifted left each step, while the partial product is
//   accumulated modulo 2^(2*WIDTH). This gives the exact two's-complement
//   product, including (-2^(WIDTH-1))^2, with no final alignment step.
//
// Ports
//   Clock          system clock, rising edge
//   Reset          asynchronous, active-low
//   Start          request, sampled in IDLE or DONE
//   Signed         0 = unsigned, 1 = signed Booth; latched with Start
//   Multiplicando  operand A (WIDTH bits)
//   Multiplicador  operand B (WIDTH bits)
//   Producto       2*WIDTH-bit result, updated only on completion
//   Ready          one-cycle completion pulse (high in DONE)
//   Busy           high while in RUN
//
// Build option
//   MULT_EARLY_TERM_EN : when defined, unsigned operations leave RUN as soon
//   as the remaining multiplier bits are all zero (minimum one RUN cycle).
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for Start
// RUN   | processing one multiplier bit per edge
// DONE  | Producto valid, Ready high; Start here begins the next op

module mult_secuencial_param #(
    parameter int WIDTH = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   Multiplicando,
    input  logic [WIDTH-1:0]   Multiplicador,
    output logic [2*WIDTH-1:0] Producto,
    output logic               Ready,
    output logic               Busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod, prod_nxt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               bm1;
    logic               sgn;
    logic               accept;
    logic               last_step;

    // one accumulation step; mplier[0] is the bit being processed and bm1
    // the previously processed bit (Booth pair)
    always_comb begin
        prod_nxt = prod;
        if (sgn) begin
            case ({mplier[0], bm1})
                2'b01:   prod_nxt = prod + mcand;
                2'b10:   prod_nxt = prod - mcand;
                default: prod_nxt = prod;
            endcase
        end else if (mplier[0]) begin
            prod_nxt = prod + mcand;
        end
    end

    always_comb begin
        last_step = (cnt == CW'(WIDTH - 1));
`ifdef MULT_EARLY_TERM_EN
        // mplier[WIDTH-1:1] are the bits still to be processed after this edge
        if (!sgn && (mplier[WIDTH-1:1] == '0))
            last_step = 1'b1;
`endif
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step)
                    state_nxt = DONE;
            end
            DONE: begin
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            bm1      <= 1'b0;
            sgn      <= 1'b0;
            cnt      <= '0;
            Producto <= '0;
        end else if (accept) begin
            prod     <= '0;
            mcand    <= Signed ? {{WIDTH{Multiplicando[WIDTH-1]}}, Multiplicando}
                               : {{WIDTH{1'b0}}, Multiplicando};
            mplier   <= Multiplicador;
            bm1      <= 1'b0;
            sgn      <= Signed;
            cnt      <= '0;
        end else if (state == RUN) begin
            prod     <= prod_nxt;
            mcand    <= mcand << 1;
            mplier   <= mplier >> 1;
            bm1      <= mplier[0];
            cnt      <= cnt + CW'(1);
            if (last_step)
                Producto <= prod_nxt;
        end
    end

    assign Ready = (state == DONE);
    assign Busy  = (state == RUN);

endmodule

// File: tb/tb_mult_secuencial_param.sv
module tb_mult_secuencial_param;

    typedef struct {
        logic [31:0] p;
        int          e0;
        int          lat;
    } sb_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st8 = 1'b0, sg8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] prod8;
    logic        rdy8, busy8;
    logic        st16 = 1'b0, sg16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] prod16;
    logic        rdy16, busy16;

    int  cyc = 0;
    int  nvec = 0;
    int  nerr = 0;
    sb_t q8[$];
    sb_t q16[$];
    logic prev_rdy8 = 1'b0, prev_rdy16 = 1'b0;
    int  last_rdy8 = 0, prev_rdy_cyc8 = 0;
    vec_t tbl[12];

    mult_secuencial_param #(.WIDTH(8)) dut8 (
        .Clock(clk), .Reset(rst_n), .Start(st8), .Signed(sg8),
        .Multiplicando(a8), .Multiplicador(b8),
        .Producto(prod8), .Ready(rdy8), .Busy(busy8)
    );

    mult_secuencial_param #(.WIDTH(16)) dut16 (
        .Clock(clk), .Reset(rst_n), .Start(st16), .Signed(sg16),
        .Multiplicando(a16), .Multiplicador(b16),
        .Producto(prod16), .Ready(rdy16), .Busy(busy16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] b, input logic s, input int w);
`ifdef MULT_EARLY_TERM_EN
        if (!s) begin
            int k = 1;
            while (k < w && (b >> k) != 0) k++;
            return k;
        end
`endif
        return w;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic s, input int w);
        longint x, y, r;
        x = longint'(a);
        y = longint'(b);
        if (s) begin
            if (a[w-1]) x = x - (longint'(1) << w);
            if (b[w-1]) y = y - (longint'(1) << w);
        end
        r = (x * y) & ((longint'(1) << (2 * w)) - 1);
        return r[31:0];
    endfunction

    // scoreboard consumers
    always @(negedge clk) begin
        sb_t it;
        if (rdy8) begin
            chk("ready8_width", {31'b0, prev_rdy8}, 32'd0);
            chk("busy8_at_ready", {31'b0, busy8}, 32'd0);
            prev_rdy_cyc8 = last_rdy8;
            last_rdy8     = cyc;
            if (q8.size() == 0) begin
                chk("ready8_unexpected", 32'd1, 32'd0);
            end else begin
                it = q8.pop_front();
                chk("prod8", {16'h0, prod8}, it.p);
                chk("lat8", 32'(cyc - it.e0), 32'(it.lat));
            end
        end
        prev_rdy8 = rdy8;
    end

    always @(negedge clk) begin
        sb_t it;
        if (rdy16) begin
            if (prev_rdy16) chk("ready16_width", 32'd1, 32'd0);
            if (q16.size() == 0) begin
                chk("ready16_unexpected", 32'd1, 32'd0);
            end else begin
                it = q16.pop_front();
                chk("prod16", prod16, it.p);
                chk("lat16", 32'(cyc - it.e0), 32'(it.lat));
            end
        end
        prev_rdy16 = rdy16;
    end

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] p, input bit push);
        int t = 0;
        @(negedge clk);
        while (busy8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy8) chk("start8_timeout", 32'd1, 32'd0);
        a8 = a; b8 = b; sg8 = s; st8 = 1'b1;
        if (push) q8.push_back('{p: {16'h0, p}, e0: cyc + 1, lat: exp_lat({8'h0, b}, s, 8)});
        @(negedge clk);
        st8 = 1'b0;
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int t = 0;
        @(negedge clk);
        while (busy16 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy16) chk("start16_timeout", 32'd1, 32'd0);
        a16 = a; b16 = b; sg16 = s; st16 = 1'b1;
        q16.push_back('{p: ref_mul(a, b, s, 16), e0: cyc + 1, lat: exp_lat(b, s, 16)});
        @(negedge clk);
        st16 = 1'b0;
    endtask

    task automatic idle8();
        int t = 0;
        while ((busy8 || rdy8 || q8.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("idle8_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle16();
        int t = 0;
        while ((busy16 || rdy16 || q16.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("idle16_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int e0;
        int lat;
        logic [15:0] ra, rb;
        logic        rs;

        tbl[0]  = '{8'hD7, 8'h17, 1'b0, 16'h1351};
        tbl[1]  = '{8'hD7, 8'h17, 1'b1, 16'hFC51};
        tbl[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        tbl[3]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        tbl[4]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        tbl[5]  = '{8'hD7, 8'h03, 1'b0, 16'h0285};
        tbl[6]  = '{8'hD7, 8'h00, 1'b0, 16'h0000};
        tbl[7]  = '{8'hD7, 8'h03, 1'b1, 16'hFF85};
        tbl[8]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        tbl[9]  = '{8'h01, 8'h80, 1'b1, 16'hFF80};
        tbl[10] = '{8'h00, 8'hFF, 1'b0, 16'h0000};
        tbl[11] = '{8'h7F, 8'h7F, 1'b0, 16'h3F01};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_prod8", {16'h0, prod8}, 32'h0);
        chk("rst_ready8", {31'b0, rdy8}, 32'h0);
        chk("rst_busy8", {31'b0, busy8}, 32'h0);
        chk("rst_prod16", prod16, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // table vectors
        for (int i = 0; i < 12; i++)
            start8(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].p, 1'b1);
        idle8();
        repeat (5) @(negedge clk);
        chk("prod8_hold", {16'h0, prod8}, {16'h0, tbl[11].p});

        // busy profile across one operation
        start8(8'hD7, 8'h17, 1'b0, 16'h1351, 1'b1);
        lat = exp_lat(16'h0017, 1'b0, 8);
        for (int i = 0; i < lat; i++) begin
            chk("busy8_run", {31'b0, busy8}, 32'd1);
            @(negedge clk);
        end
        chk("busy8_done", {31'b0, busy8}, 32'd0);
        chk("ready8_done", {31'b0, rdy8}, 32'd1);
        idle8();

        // Start re-pulsed during RUN is ignored
        start8(8'hD7, 8'h17, 1'b0, 16'h1351, 1'b1);
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; sg8 = 1'b1; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        idle8();

        // back-to-back with Start held high through DONE
        a8 = 8'h80; b8 = 8'h7F; sg8 = 1'b1; st8 = 1'b1;
        e0 = cyc + 1;
        q8.push_back('{p: 32'h0000C080, e0: e0, lat: 8});
        @(negedge clk);
        a8 = 8'hD7; b8 = 8'h17; sg8 = 1'b1;
        q8.push_back('{p: 32'h0000FC51, e0: e0 + 9, lat: 8});
        repeat (9) @(negedge clk);
        st8 = 1'b0;
        idle8();
        chk("b2b_ready_gap", 32'(last_rdy8 - prev_rdy_cyc8), 32'd9);

        // reset in the middle of RUN
        start8(8'h80, 8'h80, 1'b1, 16'h0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy8", {31'b0, busy8}, 32'd0);
        chk("abort_ready8", {31'b0, rdy8}, 32'd0);
        chk("abort_prod8", {16'h0, prod8}, 32'h0);
        @(negedge clk);
        a8 = 8'hD7; b8 = 8'h17; sg8 = 1'b0; st8 = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        st8 = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ignored", {31'b0, busy8}, 32'd0);
        start8(8'hD7, 8'h17, 1'b1, 16'hFC51, 1'b1);
        idle8();

        // WIDTH=16 corners and random pairs
        start16(16'h8000, 16'h8000, 1'b1);
        start16(16'hFFFF, 16'hFFFF, 1'b0);
        start16(16'h8000, 16'h7FFF, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            start16(ra, rb, rs);
        end
        idle16();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
